uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single `uart_tx` transmitter between `NUM_REQ` requesters, each sending fixed-length frames of `FRAME_BYTES` bytes. It sits between the requesting blocks and `uart_tx`, and drives the transmitter's `sbyte_i`/`send_i` while watching its `busy_o`. A granted requester's whole frame is captured at grant time and sent MSB byte first, back-to-back, with no interleaving between requesters.

## Interface
- `NUM_REQ`, default 4, number of requesters (2..8).
- `FRAME_BYTES`, default 3, bytes per frame (1..8).
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  asynchronous active-low reset.
- `req_i`  in  NUM_REQ  level request per requester; bit k high = requester k has a frame ready.
- `data_i`  in  NUM_REQ*FRAME_BYTES*8  frame data; requester k occupies slice `[k*FRAME_BYTES*8 +: FRAME_BYTES*8]`.
- `ack_o`  out  NUM_REQ  one-cycle pulse: the frame of requester k was captured this cycle.
- `done_o`  out  NUM_REQ  one-cycle pulse: the last byte of requester k's frame has finished on the line.
- `gnt_id_o`  out  3  index of the current or last granted requester.
- `active_o`  out  1  high from capture through the done pulse.
- `sbyte_o`  out  8  byte to transmitter (to `uart_tx.sbyte_i`).
- `send_o`  out  1  one-cycle start pulse (to `uart_tx.send_i`).
- `busy_i`  in  1  transmitter busy (from `uart_tx.busy_o`).

## Operation
- All outputs are registered. On reset, every output is 0, the state is IDLE and the priority pointer is `NUM_REQ-1`, so requester 0 has highest priority first.
- **IDLE:** if any `req_i` bit is set, select the first set bit searching from pointer+1 upward with wrap-around. Go to LOAD.
- **LOAD:**
  - Capture the selected slice into the frame shift register.
  - Set `gnt_id_o` and `active_o`.
  - Pulse `ack_o[k]`.
  - Load the byte counter with `FRAME_BYTES`.
  - Go to SEND.
- **SEND:** wait while `busy_i`=1. When `busy_i`=0:
  - Drive `sbyte_o` = top byte of the shift register and pulse `send_o`.
  - Shift the register left by 8 and decrement the counter.
  - Go to WAIT_HI.
- **WAIT_HI:** wait for `busy_i`=1, then go to WAIT_LO. Never re-pulse `send_o` here.
- **WAIT_LO:** wait for `busy_i`=0. If the counter is nonzero, go to SEND; else go to DONE.
- **DONE:**
  - Pulse `done_o[k]` and set pointer = k.
  - Clear `active_o`; `gnt_id_o` holds its value.
  - Go to IDLE.
- Requests are sampled only in IDLE. A request arriving mid-frame waits. A request dropped before grant is lost without error.
- `data_i` only needs to be valid in the cycle before `ack_o`. Changes after capture do not affect the frame in flight.
- A requester holding `req_i` high after `done_o` is granted again only per round-robin order. Another pending requester always goes first.
- `sbyte_o` holds its last value between sends.
- Asynchronous reset mid-frame immediately clears `send_o`, `active_o`, `ack_o` and `done_o`, and abandons the frame. No `done_o` is issued for it.

## Timing
- Request-to-ack latency: `req_i` high in IDLE at cycle n gives `ack_o` at n+1 and the first `send_o` at n+2, if `busy_i`=0.
- Inter-byte gap: `send_o` occurs on the first cycle with `busy_i`=0 after WAIT_LO, i.e. 2 cycles after the `busy_i` falling edge is sampled.
- Done latency: `done_o` occurs 1 cycle after WAIT_LO sees `busy_i`=0 following the last byte.
- The next grant's `ack_o` comes no earlier than 2 cycles after `done_o`.
- Frame length: exactly `FRAME_BYTES` `send_o` pulses per `ack_o`, each separated by a full busy high-then-low cycle.
- Any delay between `send_o` and `busy_i` rising is tolerated through WAIT_HI.

## Test plan
- **Single requester:** reset, then `req_i`=4'b0001 with frame 0x112233. Expect `ack_o[0]` once, `sbyte_o` sequence 0x11, 0x22, 0x33 with three `send_o` pulses, one `done_o[0]`, and `active_o` low afterwards.
- **All requesting at once:** `req_i`=4'b1111 after reset with distinct frames. Expect grant order 0,1,2,3, 12 bytes total, and frames never interleaved.
- **Fairness:** `req_i[0]` and `req_i[2]` held high continuously. Expect grants alternating 0,2,0,2 across 4 frames.
- **Busy handshake:** busy model asserts `busy_i` 5 cycles after `send_o` and holds it 20 cycles. Expect exactly one `send_o` per byte. Also start with `busy_i` stuck high for 10 cycles after ack: no `send_o` until it falls.
- **Data capture:** change `data_i` of the granted requester to 0xFFFFFF the cycle after `ack_o`. Expect the originally captured bytes on the line.
- **Reset mid-frame:** assert `rstn_i` low after the 2nd `send_o`. Expect all outputs 0 immediately, no `done_o`, and after release requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ frame requesters.
// A granted frame is captured whole and sent MSB byte first without interleaving.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned FRAME_BYTES = 3
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*FRAME_BYTES*8-1:0] data_i,
  output logic [NUM_REQ-1:0]               ack_o,
  output logic [NUM_REQ-1:0]               done_o,
  output logic [2:0]                       gnt_id_o,
  output logic                             active_o,
  output logic [7:0]                       sbyte_o,
  output logic                             send_o,
  input  logic                             busy_i
);

  localparam int unsigned FW = FRAME_BYTES * 8;
  localparam int unsigned IW = $clog2(2 * NUM_REQ);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitHi,
    StWaitLo,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          gnt_q, gnt_d;
  logic                active_q, active_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [7:0]          sbyte_q, sbyte_d;
  logic                send_q, send_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [2:0]           start;
  logic [3:0]           sel_off;
  logic [3:0]           sel_sum;
  logic                 sel_found;
  logic [2:0]           sel_idx;

  // Rotate requests so the search always begins at pointer+1, then take the lowest set bit.
  always_comb begin
    start     = (ptr_q >= 3'(NUM_REQ - 1)) ? 3'd0 : ptr_q + 3'd1;
    req_dbl   = {req_i, req_i};
    req_rot   = req_dbl[IW'(start) +: NUM_REQ];
    sel_found = |req_rot;
    sel_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) sel_off = 4'(i);
    end
    sel_sum = {1'b0, start} + sel_off;
    if (sel_sum >= 4'(NUM_REQ)) sel_sum = sel_sum - 4'(NUM_REQ);
    sel_idx = sel_sum[2:0];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    active_d = active_q;
    sbyte_d  = sbyte_q;
    ack_d    = '0;
    done_d   = '0;
    send_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (sel_found) begin
          frame_d  = FW'(data_i >> (FW * 32'(sel_idx)));
          cnt_d    = 4'(FRAME_BYTES);
          gnt_d    = sel_idx;
          active_d = 1'b1;
          ack_d    = NUM_REQ'(1) << sel_idx;
          state_d  = StLoad;
        end
      end
      // The capture is already registered while in LOAD, so the first byte can go out
      // straight from here when the transmitter is free.
      StLoad, StSend: begin
        if (!busy_i) begin
          sbyte_d = frame_q[FW-1 -: 8];
          frame_d = frame_q << 8;
          cnt_d   = cnt_q - 4'd1;
          send_d  = 1'b1;
          state_d = StWaitHi;
        end else begin
          state_d = StSend;
        end
      end
      StWaitHi: begin
        if (busy_i) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!busy_i) begin
          if (cnt_q != 4'd0) begin
            state_d = StSend;
          end else begin
            done_d  = NUM_REQ'(1) << gnt_q;
            ptr_d   = gnt_q;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      ptr_q    <= 3'(NUM_REQ - 1);
      frame_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      active_q <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      sbyte_q  <= '0;
      send_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      active_q <= active_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      sbyte_q  <= sbyte_d;
      send_q   <= send_d;
    end
  end

  assign ack_o    = ack_q;
  assign done_o   = done_q;
  assign gnt_id_o = gnt_q;
  assign active_o = active_q;
  assign sbyte_o  = sbyte_q;
  assign send_o   = send_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a busy-line model plus a grant/byte scoreboard
// filled as stimulus is driven and drained as acks, sends and dones appear.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int FB = 3;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic [N-1:0]    req_i;
  logic [N*FB*8-1:0] data_i;
  logic [N-1:0]    ack_o;
  logic [N-1:0]    done_o;
  logic [2:0]      gnt_id_o;
  logic            active_o;
  logic [7:0]      sbyte_o;
  logic            send_o;
  logic            busy_i;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .FRAME_BYTES (FB)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .req_i    (req_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .done_o   (done_o),
    .gnt_id_o (gnt_id_o),
    .active_o (active_o),
    .sbyte_o  (sbyte_o),
    .send_o   (send_o),
    .busy_i   (busy_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ack   = 0;
  int n_send  = 0;
  int n_done  = 0;
  int cur_gnt = 0;
  int mon_g;
  logic [7:0] mon_b;
  logic [7:0] exp_byte[$];
  int         exp_gnt[$];

  int   busy_delay = 1;
  int   busy_hold  = 3;
  logic busy_model = 1'b0;
  logic busy_stuck = 1'b0;
  bit   model_idle = 1'b1;

  assign busy_i = busy_model | busy_stuck;

  // Transmitter stand-in: busy rises busy_delay cycles after a send and stays up busy_hold cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (send_o && rstn_i) begin
        model_idle = 1'b0;
        repeat (busy_delay) @(negedge clk);
        busy_model = 1'b1;
        repeat (busy_hold) @(negedge clk);
        busy_model = 1'b0;
        model_idle = 1'b1;
      end
    end
  end

  // Scoreboard drain.
  always @(negedge clk) begin
    if (rstn_i) begin
      if (ack_o != '0) begin
        n_ack++;
        n_tests++;
        if (exp_gnt.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: ack_o=%b, required no ack", ack_o);
        end else begin
          mon_g   = exp_gnt.pop_front();
          cur_gnt = mon_g;
          if (ack_o !== (4'b0001 << mon_g) || gnt_id_o !== 3'(mon_g) || active_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_grant: ack_o=%b gnt_id_o=%0d active_o=%b, required ack_o=%b gnt_id_o=%0d active_o=1",
                     ack_o, gnt_id_o, active_o, 4'b0001 << mon_g, mon_g);
          end
        end
      end
      if (send_o) begin
        n_send++;
        n_tests++;
        if (exp_byte.size() == 0) begin
          n_fail++;
          $display("FAIL send_unexpected: sbyte_o=%h, required no send", sbyte_o);
        end else begin
          mon_b = exp_byte.pop_front();
          if (sbyte_o !== mon_b || gnt_id_o !== 3'(cur_gnt) || active_o !== 1'b1) begin
            n_fail++;
            $display("FAIL send_byte: sbyte_o=%h gnt_id_o=%0d active_o=%b, required sbyte_o=%h gnt_id_o=%0d active_o=1",
                     sbyte_o, gnt_id_o, active_o, mon_b, cur_gnt);
          end
        end
      end
      if (done_o != '0) begin
        n_done++;
        n_tests++;
        if (done_o !== (4'b0001 << cur_gnt) || active_o !== 1'b1) begin
          n_fail++;
          $display("FAIL done_pulse: done_o=%b active_o=%b, required done_o=%b active_o=1",
                   done_o, active_o, 4'b0001 << cur_gnt);
        end
      end
    end
  end

  task automatic push_frame(input int k, input logic [FB*8-1:0] f);
    exp_gnt.push_back(k);
    for (int b = FB - 1; b >= 0; b--) exp_byte.push_back(f[b*8 +: 8]);
    data_i[k*FB*8 +: FB*8] = f;
  endtask

  // sel: 0 = acks, 1 = sends, 2 = dones
  task automatic wait_for(input int sel, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if ((sel == 0 && n_ack >= target) || (sel == 1 && n_send >= target) ||
          (sel == 2 && n_done >= target)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rstn_i     = 1'b0;
    req_i      = '0;
    busy_stuck = 1'b0;
    repeat (3) @(negedge clk);
    exp_byte.delete();
    exp_gnt.delete();
    #1;
    rstn_i = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    req_i  = '0;
    data_i = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ack_o, done_o, gnt_id_o, active_o, sbyte_o, send_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b done=%b gnt=%0d active=%b sbyte=%h send=%b, required all 0",
               ack_o, done_o, gnt_id_o, active_o, sbyte_o, send_o);
    end
    #1;
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ack_o, active_o, send_o} !== '0) begin
      n_fail++;
      $display("FAIL idle_no_req: ack=%b active=%b send=%b, required 0", ack_o, active_o, send_o);
    end
  endtask

  task automatic test_single();
    int a0 = n_ack;
    int s0 = n_send;
    int d0 = n_done;
    bit ok;
    @(negedge clk);
    push_frame(0, 24'h112233);
    req_i = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (ack_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ack_latency: ack_o=%b, required 0001", ack_o);
    end
    req_i = '0;
    @(negedge clk);
    n_tests++;
    if (send_o !== 1'b1 || sbyte_o !== 8'h11) begin
      n_fail++;
      $display("FAIL single_send_latency: send_o=%b sbyte_o=%h, required 1 and 11", send_o, sbyte_o);
    end
    wait_for(2, d0 + 1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_done_timeout: dones=%0d, required %0d", n_done - d0, 1);
    end
    @(negedge clk);
    n_tests++;
    if (active_o !== 1'b0 || n_ack - a0 != 1 || n_send - s0 != 3 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL single_counts: active=%b acks=%0d sends=%0d dones=%0d, required 0/1/3/1",
               active_o, n_ack - a0, n_send - s0, n_done - d0);
    end
  endtask

  task automatic test_all_at_once();
    int s0;
    int d0;
    bit ok;
    apply_reset();
    s0 = n_send;
    d0 = n_done;
    push_frame(0, 24'hA1A2A3);
    push_frame(1, 24'hB1B2B3);
    push_frame(2, 24'hC1C2C3);
    push_frame(3, 24'hD1D2D3);
    req_i = 4'b1111;
    wait_for(0, n_ack + 4, ok);
    req_i = '0;
    if (ok) wait_for(2, d0 + 4, ok);
    n_tests++;
    if (!ok || n_send - s0 != 12 || exp_byte.size() != 0) begin
      n_fail++;
      $display("FAIL all_at_once: completed=%b sends=%0d leftover=%0d, required 1/12/0",
               ok, n_send - s0, exp_byte.size());
    end
  endtask

  task automatic test_fairness();
    int d0 = n_done;
    bit ok;
    push_frame(0, 24'h010203);
    push_frame(2, 24'h212223);
    push_frame(0, 24'h010203);
    push_frame(2, 24'h212223);
    req_i = 4'b0101;
    wait_for(0, n_ack + 4, ok);
    req_i = '0;
    if (ok) wait_for(2, d0 + 4, ok);
    n_tests++;
    if (!ok || exp_gnt.size() != 0) begin
      n_fail++;
      $display("FAIL fairness: completed=%b pending_grants=%0d, required 1/0", ok, exp_gnt.size());
    end
  endtask

  task automatic test_busy_handshake();
    int s0 = n_send;
    int d0 = n_done;
    bit ok;
    busy_delay = 5;
    busy_hold  = 20;
    push_frame(2, 24'h778899);
    req_i = 4'b0100;
    wait_for(0, n_ack + 1, ok);
    req_i = '0;
    if (ok) wait_for(2, d0 + 1, ok);
    n_tests++;
    if (!ok || n_send - s0 != 3) begin
      n_fail++;
      $display("FAIL busy_handshake: completed=%b sends=%0d, required 1/3", ok, n_send - s0);
    end
    busy_delay = 1;
    busy_hold  = 3;
  endtask

  task automatic test_busy_stuck();
    int s0 = n_send;
    int d0 = n_done;
    int early = 0;
    bit ok;
    busy_stuck = 1'b1;
    push_frame(3, 24'hAABBCC);
    req_i = 4'b1000;
    wait_for(0, n_ack + 1, ok);
    req_i = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (send_o) early++;
    end
    n_tests++;
    if (!ok || early != 0) begin
      n_fail++;
      $display("FAIL busy_stuck_hold: acked=%b sends_while_busy=%0d, required 1/0", ok, early);
    end
    #1;
    busy_stuck = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (n_send - s0 != 1) begin
      n_fail++;
      $display("FAIL busy_stuck_release: sends=%0d, required 1", n_send - s0);
    end
    wait_for(2, d0 + 1, ok);
    n_tests++;
    if (!ok || n_send - s0 != 3) begin
      n_fail++;
      $display("FAIL busy_stuck_frame: completed=%b sends=%0d, required 1/3", ok, n_send - s0);
    end
  endtask

  task automatic test_data_capture();
    int d0 = n_done;
    bit ok;
    push_frame(1, 24'h445566);
    req_i = 4'b0010;
    wait_for(0, n_ack + 1, ok);
    data_i[1*FB*8 +: FB*8] = 24'hFFFFFF;
    req_i = '0;
    if (ok) wait_for(2, d0 + 1, ok);
    n_tests++;
    if (!ok || exp_byte.size() != 0) begin
      n_fail++;
      $display("FAIL data_capture: completed=%b leftover=%0d, required 1/0", ok, exp_byte.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int s0 = n_send;
    int d0;
    int stray = 0;
    bit ok;
    push_frame(2, 24'h5A6B7C);
    req_i = 4'b0100;
    wait_for(1, s0 + 2, ok);
    #1;
    rstn_i = 1'b0;
    #1;
    n_tests++;
    if (!ok || {ack_o, done_o, gnt_id_o, active_o, sbyte_o, send_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_frame_outputs: reached=%b ack=%b done=%b gnt=%0d active=%b sbyte=%h send=%b, required 1 and all 0",
               ok, ack_o, done_o, gnt_id_o, active_o, sbyte_o, send_o);
    end
    exp_byte.delete();
    exp_gnt.delete();
    push_frame(0, 24'h0A0B0C);
    req_i = 4'b1001;
    d0    = n_done;
    for (int i = 0; i < 100 && !(model_idle && i > 2); i++) begin
      @(negedge clk);
      if (done_o != '0) stray++;
    end
    #1;
    rstn_i = 1'b1;
    wait_for(0, n_ack + 1, ok);
    req_i = '0;
    if (ok) wait_for(2, d0 + 1, ok);
    @(negedge clk);
    n_tests++;
    if (!ok || stray != 0 || n_done - d0 != 1 || exp_gnt.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_frame_regrant: completed=%b stray_done=%0d dones=%0d pending=%0d, required 1/0/1/0",
               ok, stray, n_done - d0, exp_gnt.size());
    end
  endtask

  initial begin
    busy_stuck = 1'b0;
    test_reset();
    test_single();
    test_all_at_once();
    test_fairness();
    test_busy_handshake();
    test_busy_stuck();
    test_data_capture();
    test_reset_mid_frame();
    n_tests++;
    if (exp_byte.size() != 0 || exp_gnt.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: bytes=%0d grants=%0d, required 0/0", exp_byte.size(), exp_gnt.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

endmodule
